piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 93 +++++++++
 tb/tb_piso_serializer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shift register with frame tracking.
// A parallel load starts a frame. Each un-inhibited clock then shifts one bit
// out of q (MSB-first or LSB-first), and done pulses for one cycle once the
// whole frame has been shifted. With no frame in flight, the register keeps
// shifting as a plain cascade stage: shift_in data moves through to q.
// WIDTH legal range: 2..64.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_inh,
  input  logic                       shld,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       shift_in,
  output logic                       q,
  output logic                       q_n,
  output logic [WIDTH-1:0]           q_par,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // Registers start at their reset values so the block is well defined
  // before the first reset edge.
  logic [WIDTH-1:0] shift_reg = '0;
  logic [CW-1:0]    cnt_reg   = '0;
  logic             busy_reg  = 1'b0;
  logic             done_reg  = 1'b0;

  logic [WIDTH-1:0] shift_next;
  logic             last_shift;

  // Register contents after one shift, in the configured bit order.
  generate
    if (LSB_FIRST) begin : g_lsb
      always_comb shift_next = {shift_in, shift_reg[WIDTH-1:1]};
    end else begin : g_msb
      always_comb shift_next = {shift_reg[WIDTH-2:0], shift_in};
    end
  endgenerate

  // This shift completes the frame only while a frame is actually in flight;
  // cascade shifts after completion never count.
  assign last_shift = busy_reg && (cnt_reg == CNT_LAST);

  // Priority: reset, then load, then inhibit, then shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (!shld) begin
      shift_reg <= data_in;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else if (clk_inh) begin
      done_reg  <= 1'b0;
    end else begin
      shift_reg <= shift_next;
      if (cnt_reg != CNT_FULL) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      done_reg  <= last_shift;
      if (last_shift) begin
        busy_reg <= 1'b0;
      end
    end
  end

  // Serial and parallel views come straight off the register, no added delay.
  generate
    if (LSB_FIRST) begin : g_q_lsb
      assign q = shift_reg[0];
    end else begin : g_q_msb
      assign q = shift_reg[WIDTH-1];
    end
  endgenerate

  assign q_n     = ~q;
  assign q_par   = shift_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign bit_cnt = cnt_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one MSB-first and one LSB-first instance share
// the same stimulus; a reference model tracks register contents as integers.
module tb_piso_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_inh = 1'b0;
  logic shld = 1'b1;
  logic [W-1:0] data_in = '0;
  logic shift_in = 1'b0;

  logic q_m, qn_m, busy_m, done_m;
  logic q_l, qn_l, busy_l, done_l;
  logic [W-1:0] qp_m, qp_l;
  logic [3:0] cnt_m, cnt_l;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .clk_inh(clk_inh), .shld(shld), .data_in(data_in),
    .shift_in(shift_in), .q(q_m), .q_n(qn_m), .q_par(qp_m), .busy(busy_m),
    .done(done_m), .bit_cnt(cnt_m));

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .clk_inh(clk_inh), .shld(shld), .data_in(data_in),
    .shift_in(shift_in), .q(q_l), .q_n(qn_l), .q_par(qp_l), .busy(busy_l),
    .done(done_l), .bit_cnt(cnt_l));

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Reference model: register values as plain integers.
  int m_msb = 0, m_lsb = 0, m_cnt = 0, m_done = 0, m_busy = 0;
  int done_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("msb_q_par", 64'(qp_m), 64'(m_msb));
    chk("lsb_q_par", 64'(qp_l), 64'(m_lsb));
    chk("msb_q", 64'(q_m), 64'(m_msb / 128));
    chk("lsb_q", 64'(q_l), 64'(m_lsb % 2));
    chk("msb_q_n", 64'(qn_m), 64'(1 - m_msb / 128));
    chk("lsb_q_n", 64'(qn_l), 64'(1 - m_lsb % 2));
    chk("msb_bit_cnt", 64'(cnt_m), 64'(m_cnt));
    chk("lsb_bit_cnt", 64'(cnt_l), 64'(m_cnt));
    chk("msb_busy", 64'(busy_m), 64'(m_busy));
    chk("lsb_busy", 64'(busy_l), 64'(m_busy));
    chk("msb_done", 64'(done_m), 64'(m_done));
    chk("lsb_done", 64'(done_l), 64'(m_done));
  endtask

  // One clock with the given inputs; model updated from the behaviour rules.
  task automatic step(input logic r, input logic ld_n, input logic inh,
                      input logic [W-1:0] d, input logic si);
    rst = r; shld = ld_n; clk_inh = inh; data_in = d; shift_in = si;
    @(posedge clk);
    #1;
    if (r) begin
      m_msb = 0; m_lsb = 0; m_cnt = 0; m_busy = 0; m_done = 0;
    end else if (!ld_n) begin
      m_msb = int'(d); m_lsb = int'(d); m_cnt = 0; m_busy = 1; m_done = 0;
    end else if (inh) begin
      m_done = 0;
    end else begin
      m_done = (m_busy == 1 && m_cnt == W - 1) ? 1 : 0;
      if (m_done == 1) m_busy = 0;
      m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
      m_msb = (m_msb * 2 + int'(si)) % 256;
      m_lsb = m_lsb / 2 + int'(si) * 128;
    end
    done_seen += m_done;
    check_all();
  endtask

  logic [7:0] pat;

  initial begin
    // Power-up state before any reset edge.
    #1;
    check_all();

    step(1, 1, 0, 8'h00, 0);

    // MSB/LSB-first frame of 0xA5: both orders give 1,0,1,0,0,1,0,1.
    pat = 8'b1010_0101;
    step(0, 0, 0, 8'hA5, 0);
    chk("a5_load_par", 64'(qp_m), 64'hA5);
    for (int i = 0; i < 8; i++) begin
      chk("a5_msb_seq", 64'(q_m), 64'(pat[7-i]));
      chk("a5_lsb_seq", 64'(q_l), 64'(pat[i]));
      step(0, 1, 0, 8'h00, 0);
    end
    chk("a5_done", 64'(done_m), 64'd1);
    chk("a5_busy_low", 64'(busy_m), 64'd0);
    chk("a5_msb_empty", 64'(qp_m), 64'h00);

    // Cascade after done: ones fill the register, no further done.
    done_seen = 0;
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h00, 1);
    chk("cascade_par", 64'(qp_m), 64'hFF);
    chk("cascade_cnt", 64'(cnt_m), 64'd8);
    chk("cascade_no_done", 64'(done_seen), 64'd0);

    // Inhibit mid-frame: count frozen, done only after the 8th shift.
    done_seen = 0;
    step(0, 0, 0, 8'hFF, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 8'h00, 1);
      chk("inh_cnt_held", 64'(cnt_m), 64'd3);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00, 0);
    chk("inh_no_early_done", 64'(done_seen), 64'd0);
    step(0, 1, 0, 8'h00, 0);
    chk("inh_done_after_8", 64'(done_m), 64'd1);

    // Reload mid-frame with inhibit asserted: load wins, no done.
    done_seen = 0;
    step(0, 0, 0, 8'h0F, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00, 0);
    step(0, 0, 1, 8'hF0, 0);
    chk("reload_par", 64'(qp_m), 64'hF0);
    chk("reload_cnt", 64'(cnt_m), 64'd0);
    chk("reload_busy", 64'(busy_m), 64'd1);
    chk("reload_no_done", 64'(done_seen), 64'd0);

    // Load coinciding with the final shift: done stays low.
    for (int i = 0; i < 7; i++) step(0, 1, 0, 8'h00, 0);
    step(0, 0, 0, 8'h3C, 0);
    chk("load_vs_last_done", 64'(done_m), 64'd0);

    // Reset at bit_cnt=4 with load requested: reset wins.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00, 1);
    chk("pre_rst_cnt", 64'(cnt_m), 64'd4);
    step(1, 0, 1, 8'h77, 1);
    chk("rst_par", 64'(qp_m), 64'h00);
    chk("rst_q_n", 64'(qn_m), 64'd1);
    chk("rst_busy", 64'(busy_m), 64'd0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h00, 0);
    chk("rst_frame_no_done", 64'(done_m), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 10) ? 1'b0 : 1'b1,
           ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
           8'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
